bram_instr_split: RTL and testbench

Descriptor splitter that sits directly upstream of the dual-bank BRAM stream slave and drives its 64-bit instruction port. It accepts one descriptor with a start address and a total beat count. It emits a sequence of AXI-Stream instructions `{addr[25:13], length[12:0]}`, each capped at MAX_LEN beats and never crossing the 13-bit address wrap. Instructions are issued one at a time under full valid/ready handshake.

---
 rtl/bram_stream_pkg.sv | 29 ++
 rtl/bram_chunk_calc.sv | 36 +++
 rtl/bram_instr_split.sv | 146 ++++++++++++++
 tb/tb_bram_instr_split.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_stream_pkg.sv
// rtl/bram_stream_pkg.sv - shared BRAM stream field widths, offsets and splitter state type
package bram_stream_pkg;

    localparam int BRAM_ADDR_W  = 13;
    localparam int BRAM_LEN_W   = 13;
    localparam int BRAM_DEPTH   = 8192;

    localparam int LEN_LSB      = 0;
    localparam int ADDR_LSB     = 13;

    // Descriptor: total beats at the bottom, 13-bit start address directly above it.
    localparam int DESC_TOT_LSB = 0;
    localparam int DESC_ADDR_W  = BRAM_ADDR_W;

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } split_state_t;

    function automatic logic [63:0] pack_instr(input logic [BRAM_ADDR_W-1:0] addr,
                                               input logic [BRAM_LEN_W-1:0]  len);
        logic [63:0] instr;
        instr = '0;
        instr[LEN_LSB +: BRAM_LEN_W]   = len;
        instr[ADDR_LSB +: BRAM_ADDR_W] = addr;
        return instr;
    endfunction

endpackage

// File: rtl/bram_chunk_calc.sv
// rtl/bram_chunk_calc.sv - chunk = min(rem, MAX_LEN, distance to address wrap)
module bram_chunk_calc
    import bram_stream_pkg::*;
#(
    parameter int MAX_LEN = 256,
    parameter int TOT_W   = 20
) (
    input  logic [BRAM_ADDR_W-1:0] addr,
    input  logic [TOT_W-1:0]       rem,
    output logic [BRAM_LEN_W-1:0]  chunk,
    output logic                   is_last
);

    localparam int CW = (TOT_W > 14) ? TOT_W : 14;

    logic [13:0]   to_wrap;
    logic [CW-1:0] rem_w;
    logic [CW-1:0] wrap_w;
    logic [CW-1:0] max_w;
    logic [CW-1:0] min_a;
    logic [CW-1:0] min_b;

    // 8192 - addr never underflows and is at least 1, so 14 bits suffice.
    assign to_wrap = 14'(BRAM_DEPTH) - {1'b0, addr};
    assign rem_w   = CW'(rem);
    assign wrap_w  = CW'(to_wrap);
    assign max_w   = CW'(MAX_LEN);

    assign min_a   = (rem_w < max_w) ? rem_w : max_w;
    assign min_b   = (min_a < wrap_w) ? min_a : wrap_w;

    // Bounded by MAX_LEN (<= 8191), so the low 13 bits carry the whole value.
    assign chunk   = min_b[BRAM_LEN_W-1:0];
    assign is_last = (min_b == rem_w);

endmodule

// File: rtl/bram_instr_split.sv
// rtl/bram_instr_split.sv - descriptor to BRAM instruction splitter; optional BRAM_INSTR_SPLIT_STAT_EN counters
module bram_instr_split
    import bram_stream_pkg::*;
#(
    parameter int MAX_LEN = 256,
    parameter int TOT_W   = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] s_desc_tdata,
    input  logic        s_desc_tvalid,
    output logic        s_desc_tready,
    output logic [63:0] m_instruct_tdata,
    output logic        m_instruct_tvalid,
    input  logic        m_instruct_tready,
    output logic        m_instruct_tlast,
    output logic        busy
`ifdef BRAM_INSTR_SPLIT_STAT_EN
    ,
    output logic [31:0] stat_instr_cnt,
    output logic [15:0] stat_desc_cnt
`endif
);

    split_state_t state;
    split_state_t state_nxt;

    logic [BRAM_ADDR_W-1:0] addr_q;
    logic [TOT_W-1:0]       rem_q;

    logic [BRAM_ADDR_W-1:0] desc_addr;
    logic [TOT_W-1:0]       desc_tot;
    logic [BRAM_LEN_W-1:0]  cur_len;
    logic [BRAM_ADDR_W-1:0] nxt_addr;
    logic [TOT_W-1:0]       nxt_rem;
    logic [BRAM_ADDR_W-1:0] calc_addr;
    logic [TOT_W-1:0]       calc_rem;
    logic [BRAM_LEN_W-1:0]  chunk;
    logic                   is_last;

    logic                   desc_hs;
    logic                   instr_hs;
    logic                   latch;
    logic                   load;
    logic                   unused_desc_bits;

    assign desc_addr        = s_desc_tdata[TOT_W +: DESC_ADDR_W];
    assign desc_tot         = s_desc_tdata[DESC_TOT_LSB +: TOT_W];
    assign unused_desc_bits = ^s_desc_tdata[63:TOT_W+DESC_ADDR_W];

    // The presented instruction's length is the chunk being retired on handshake.
    assign cur_len   = m_instruct_tdata[LEN_LSB +: BRAM_LEN_W];
    assign nxt_addr  = addr_q + cur_len;
    assign nxt_rem   = rem_q - TOT_W'(cur_len);

    assign calc_addr = (state == ST_IDLE) ? desc_addr : nxt_addr;
    assign calc_rem  = (state == ST_IDLE) ? desc_tot  : nxt_rem;

    bram_chunk_calc #(
        .MAX_LEN (MAX_LEN),
        .TOT_W   (TOT_W)
    ) u_chunk_calc (
        .addr    (calc_addr),
        .rem     (calc_rem),
        .chunk   (chunk),
        .is_last (is_last)
    );

    assign desc_hs  = s_desc_tvalid && (state == ST_IDLE);
    assign instr_hs = m_instruct_tready && (state == ST_ISSUE);

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (desc_hs) begin
                    latch = 1'b1;
                    if (desc_tot != '0) begin
                        load      = 1'b1;
                        state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (instr_hs) begin
                    latch = 1'b1;
                    if (nxt_rem == '0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q           <= '0;
            rem_q            <= '0;
            m_instruct_tdata <= '0;
            m_instruct_tlast <= 1'b0;
        end else begin
            if (latch) begin
                addr_q <= calc_addr;
                rem_q  <= calc_rem;
            end
            if (load) begin
                m_instruct_tdata <= pack_instr(calc_addr, chunk);
                m_instruct_tlast <= is_last;
            end
        end
    end

    assign s_desc_tready     = (state == ST_IDLE);
    assign m_instruct_tvalid = (state == ST_ISSUE);
    assign busy              = (state == ST_ISSUE);

`ifdef BRAM_INSTR_SPLIT_STAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_instr_cnt <= '0;
            stat_desc_cnt  <= '0;
        end else begin
            if (instr_hs) begin
                stat_instr_cnt <= stat_instr_cnt + 32'd1;
            end
            if (desc_hs && (desc_tot != '0)) begin
                stat_desc_cnt <= stat_desc_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bram_instr_split.sv
// tb/tb_bram_instr_split.sv - directed self-checking bench for bram_instr_split
module tb_bram_instr_split;

    localparam int MAX_LEN = 256;
    localparam int TOT_W   = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] s_desc_tdata = '0;
    logic        s_desc_tvalid = 1'b0;
    logic        s_desc_tready;
    logic [63:0] m_instruct_tdata;
    logic        m_instruct_tvalid;
    logic        m_instruct_tready = 1'b1;
    logic        m_instruct_tlast;
    logic        busy;
`ifdef BRAM_INSTR_SPLIT_STAT_EN
    logic [31:0] stat_instr_cnt;
    logic [15:0] stat_desc_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int hs_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && m_instruct_tvalid && m_instruct_tready) hs_cnt = hs_cnt + 1;
    end

    bram_instr_split #(
        .MAX_LEN (MAX_LEN),
        .TOT_W   (TOT_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .s_desc_tdata      (s_desc_tdata),
        .s_desc_tvalid     (s_desc_tvalid),
        .s_desc_tready     (s_desc_tready),
        .m_instruct_tdata  (m_instruct_tdata),
        .m_instruct_tvalid (m_instruct_tvalid),
        .m_instruct_tready (m_instruct_tready),
        .m_instruct_tlast  (m_instruct_tlast),
        .busy              (busy)
`ifdef BRAM_INSTR_SPLIT_STAT_EN
        ,
        .stat_instr_cnt    (stat_instr_cnt),
        .stat_desc_cnt     (stat_desc_cnt)
`endif
    );

    function automatic logic [63:0] mk(input int a, input int l);
        return (64'(a) << 13) | 64'(l);
    endfunction

    // Entered and left on a falling edge; returns on the edge after the accepting rising edge.
    task automatic send_desc(input int a, input int tot);
        int n;
        s_desc_tdata  = (64'(a) << TOT_W) | 64'(tot);
        s_desc_tvalid = 1'b1;
        n = 0;
        while (s_desc_tready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL desc_accept: tready=%b after %0d cycles, required 1", s_desc_tready, n);
        end
        @(negedge clk);
        s_desc_tvalid = 1'b0;
        s_desc_tdata  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (s_desc_tready !== 1'b1 || m_instruct_tvalid !== 1'b0 || m_instruct_tdata !== 64'd0 ||
            m_instruct_tlast !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b data=%h last=%b busy=%b, required 1 0 0 0 0",
                     s_desc_tready, m_instruct_tvalid, m_instruct_tdata, m_instruct_tlast, busy);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // 600 beats from address 0, with a second descriptor held pending the whole time.
    task automatic test_split_back_to_back();
        int ea[3] = '{0, 256, 512};
        int el[3] = '{256, 256, 88};
        send_desc(0, 600);
        s_desc_tdata  = (64'(20) << TOT_W) | 64'(2);
        s_desc_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (m_instruct_tvalid !== 1'b1 || m_instruct_tdata !== mk(ea[i], el[i]) ||
                m_instruct_tlast !== (i == 2) || s_desc_tready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL split_%0d: vld=%b data=%h last=%b rdy=%b busy=%b, required 1 %h %b 0 1",
                         i, m_instruct_tvalid, m_instruct_tdata, m_instruct_tlast, s_desc_tready, busy,
                         mk(ea[i], el[i]), (i == 2));
            end
            @(negedge clk);
        end
        checks++;
        if (m_instruct_tvalid !== 1'b0 || s_desc_tready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL split_bubble: vld=%b rdy=%b busy=%b, required 0 1 0",
                     m_instruct_tvalid, s_desc_tready, busy);
        end
        @(negedge clk);
        s_desc_tvalid = 1'b0;
        checks++;
        if (m_instruct_tvalid !== 1'b1 || m_instruct_tdata !== mk(20, 2) || m_instruct_tlast !== 1'b1) begin
            errors++;
            $display("FAIL pending_desc: vld=%b data=%h last=%b, required 1 %h 1",
                     m_instruct_tvalid, m_instruct_tdata, m_instruct_tlast, mk(20, 2));
        end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int ea[2] = '{8100, 0};
        int el[2] = '{92, 108};
        send_desc(8100, 200);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (m_instruct_tvalid !== 1'b1 || m_instruct_tdata !== mk(ea[i], el[i]) ||
                m_instruct_tlast !== (i == 1)) begin
                errors++;
                $display("FAIL wrap_%0d: vld=%b data=%h last=%b, required 1 %h %b",
                         i, m_instruct_tvalid, m_instruct_tdata, m_instruct_tlast, mk(ea[i], el[i]), (i == 1));
            end
            @(negedge clk);
        end
        checks++;
        if (m_instruct_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_end: vld=%b, required 0", m_instruct_tvalid);
        end
    endtask

    task automatic test_zero_total();
        send_desc(9, 0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (m_instruct_tvalid !== 1'b0 || s_desc_tready !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL zero_%0d: vld=%b rdy=%b busy=%b, required 0 1 0",
                         i, m_instruct_tvalid, s_desc_tready, busy);
            end
            @(negedge clk);
        end
        send_desc(5, 3);
        checks++;
        if (m_instruct_tvalid !== 1'b1 || m_instruct_tdata !== mk(5, 3) || m_instruct_tlast !== 1'b1) begin
            errors++;
            $display("FAIL zero_next: vld=%b data=%h last=%b, required 1 %h 1",
                     m_instruct_tvalid, m_instruct_tdata, m_instruct_tlast, mk(5, 3));
        end
        @(negedge clk);
        checks++;
        if (m_instruct_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL zero_next_end: vld=%b, required 0", m_instruct_tvalid);
        end
    endtask

    task automatic test_backpressure();
        int start;
        start = hs_cnt;
        send_desc(0, 600);
        @(negedge clk);
        m_instruct_tready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (m_instruct_tvalid !== 1'b1 || m_instruct_tdata !== mk(256, 256) || m_instruct_tlast !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: vld=%b data=%h last=%b, required 1 %h 0",
                         i, m_instruct_tvalid, m_instruct_tdata, m_instruct_tlast, mk(256, 256));
            end
            if (i < 5) @(negedge clk);
        end
        m_instruct_tready = 1'b1;
        @(negedge clk);
        checks++;
        if (m_instruct_tvalid !== 1'b1 || m_instruct_tdata !== mk(512, 88) || m_instruct_tlast !== 1'b1) begin
            errors++;
            $display("FAIL bp_third: vld=%b data=%h last=%b, required 1 %h 1",
                     m_instruct_tvalid, m_instruct_tdata, m_instruct_tlast, mk(512, 88));
        end
        @(negedge clk);
        checks++;
        if (m_instruct_tvalid !== 1'b0 || hs_cnt - start !== 3) begin
            errors++;
            $display("FAIL bp_count: vld=%b handshakes=%0d, required 0 3", m_instruct_tvalid, hs_cnt - start);
        end
    endtask

    task automatic test_reset_mid();
        send_desc(100, 1000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (m_instruct_tvalid !== 1'b0 || busy !== 1'b0 || s_desc_tready !== 1'b1 ||
            m_instruct_tdata !== 64'd0 || m_instruct_tlast !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: vld=%b busy=%b rdy=%b data=%h last=%b, required 0 0 1 0 0",
                     m_instruct_tvalid, busy, s_desc_tready, m_instruct_tdata, m_instruct_tlast);
        end
        send_desc(7, 2);
        checks++;
        if (m_instruct_tvalid !== 1'b1 || m_instruct_tdata !== mk(7, 2) || m_instruct_tlast !== 1'b1) begin
            errors++;
            $display("FAIL reset_restart: vld=%b data=%h last=%b, required 1 %h 1",
                     m_instruct_tvalid, m_instruct_tdata, m_instruct_tlast, mk(7, 2));
        end
        @(negedge clk);
        checks++;
        if (m_instruct_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_restart_end: vld=%b, required 0", m_instruct_tvalid);
        end
    endtask

`ifdef BRAM_INSTR_SPLIT_STAT_EN
    task automatic test_stats();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send_desc(0, 600);
        repeat (4) @(negedge clk);
        send_desc(8100, 200);
        repeat (3) @(negedge clk);
        checks++;
        if (stat_instr_cnt !== 32'd5 || stat_desc_cnt !== 16'd2) begin
            errors++;
            $display("FAIL stats: instr=%0d desc=%0d, required 5 2", stat_instr_cnt, stat_desc_cnt);
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_split_back_to_back();
        test_wrap();
        test_zero_total();
        test_backpressure();
        test_reset_mid();
`ifdef BRAM_INSTR_SPLIT_STAT_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
